infra_sram_1r1w_resp: RTL and testbench

Behavioural-synthesizable responder for the physical-memory side of the aligned ECC 1R1W controller. It accepts one masked row write and one row read per cycle on the `mem_*` interface and returns read data after a fixed `SRAM_DELAY` pipeline. It also supplies the forwarding flag and physical row address the controller consumes. It sits below the controller core in IP-level benches and FPGA prototypes, standing in for the compiled SRAM macro.

---
 rtl/infra_sram_1r1w_resp.sv | 135 +++++++++++++
 tb/tb_infra_sram_1r1w_resp.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/infra_sram_1r1w_resp.sv
// Behavioural 1R1W row memory: masked row writes, write-first forwarding on same-row collisions, optional zero-fill after reset.
// Latency: SRAM_DELAY cycles from read issue to registered outputs; one read and one write accepted per cycle.
// No backpressure: strobes are honoured whenever mem_ready is high. `define INFRA_SRAM_ERRINJ_EN adds read-data error injection.
module infra_sram_1r1w_resp #(
    parameter int MEMWDTH    = 39,
    parameter int NUMWRDS    = 4,
    parameter int BITWRDS    = 2,
    parameter int NUMSROW    = 256,
    parameter int BITSROW    = 8,
    parameter int BITPADR    = 10,
    parameter int SRAM_DELAY = 2,
    parameter int RSTZERO    = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mem_write,
    input  logic [BITSROW-1:0]               mem_wr_adr,
    input  logic [NUMWRDS*MEMWDTH-1:0]       mem_bw,
    input  logic [NUMWRDS*MEMWDTH-1:0]       mem_din,
    input  logic                             mem_read,
    input  logic [BITSROW-1:0]               mem_rd_adr,
`ifdef INFRA_SRAM_ERRINJ_EN
    input  logic                             inj_en,
    input  logic [NUMWRDS*MEMWDTH-1:0]       inj_mask,
`endif
    output logic [NUMWRDS*MEMWDTH-1:0]       mem_rd_dout,
    output logic                             mem_rd_vld,
    output logic                             mem_rd_fwrd,
    output logic [BITPADR-BITWRDS-1:0]       mem_rd_padr,
    output logic                             mem_ready
);
    localparam int ROWW  = NUMWRDS * MEMWDTH;
    localparam int PADRW = BITPADR - BITWRDS;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state, state_nxt;
    logic [BITSROW-1:0] init_cnt;
    logic               init_last;

    logic [ROWW-1:0]    mem [NUMSROW];

    logic               wr_hit;
    logic               arr_we;
    logic [BITSROW-1:0] arr_adr;
    logic [ROWW-1:0]    arr_bw, arr_din;

    logic               rd_go, rd_inrng, rd_fwd;
    logic [ROWW-1:0]    rd_row, rd_data;

    logic               pl_vld  [SRAM_DELAY];
    logic [ROWW-1:0]    pl_dat  [SRAM_DELAY];
    logic               pl_fwd  [SRAM_DELAY];
    logic [PADRW-1:0]   pl_padr [SRAM_DELAY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= (RSTZERO != 0) ? INIT : RUN;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                init_cnt <= init_cnt + 1'b1;
        end
    end

    assign init_last = (32'(init_cnt) == NUMSROW - 1);

    always_comb begin
        state_nxt = state;
        if (state == INIT && init_last)
            state_nxt = RUN;
    end

    assign mem_ready = (state == RUN);

    // Init sequencer borrows the write port; user strobes are ignored until RUN.
    assign wr_hit  = mem_write && mem_ready && (32'(mem_wr_adr) < NUMSROW);
    assign arr_we  = (state == INIT) || wr_hit;
    assign arr_adr = (state == INIT) ? init_cnt : mem_wr_adr;
    assign arr_bw  = (state == INIT) ? '1 : mem_bw;
    assign arr_din = (state == INIT) ? '0 : mem_din;

    // Array is never reset; writes are simply suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst && arr_we)
            mem[arr_adr] <= (mem[arr_adr] & ~arr_bw) | (arr_din & arr_bw);
    end

    assign rd_go    = mem_read && mem_ready;
    assign rd_inrng = (32'(mem_rd_adr) < NUMSROW);
    assign rd_fwd   = wr_hit && (mem_wr_adr == mem_rd_adr);

    always_comb begin
        rd_row  = rd_inrng ? mem[mem_rd_adr] : '0;
        rd_data = rd_fwd ? ((rd_row & ~mem_bw) | (mem_din & mem_bw)) : rd_row;
`ifdef INFRA_SRAM_ERRINJ_EN
        if (inj_en)
            rd_data = rd_data ^ inj_mask;
`endif
    end

    // Payload registers only load behind a valid beat so outputs hold between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SRAM_DELAY; i++) begin
                pl_vld[i]  <= 1'b0;
                pl_dat[i]  <= '0;
                pl_fwd[i]  <= 1'b0;
                pl_padr[i] <= '0;
            end
        end else begin
            pl_vld[0] <= rd_go;
            if (rd_go) begin
                pl_dat[0]  <= rd_data;
                pl_fwd[0]  <= rd_fwd;
                pl_padr[0] <= PADRW'(mem_rd_adr);
            end
            for (int i = 1; i < SRAM_DELAY; i++) begin
                pl_vld[i] <= pl_vld[i-1];
                if (pl_vld[i-1]) begin
                    pl_dat[i]  <= pl_dat[i-1];
                    pl_fwd[i]  <= pl_fwd[i-1];
                    pl_padr[i] <= pl_padr[i-1];
                end
            end
        end
    end

    assign mem_rd_vld  = pl_vld[SRAM_DELAY-1];
    assign mem_rd_dout = pl_dat[SRAM_DELAY-1];
    assign mem_rd_fwrd = pl_fwd[SRAM_DELAY-1];
    assign mem_rd_padr = pl_padr[SRAM_DELAY-1];

endmodule

// File: tb/tb_infra_sram_1r1w_resp.sv
// Directed bench: one instance without zero-init (u_dut0) and one with zero-init (u_dut1) share stimulus.
`timescale 1ns/1ps
module tb_infra_sram_1r1w_resp;
    localparam int MEMWDTH    = 8;
    localparam int NUMWRDS    = 4;
    localparam int BITWRDS    = 2;
    localparam int NUMSROW    = 16;
    localparam int BITSROW    = 4;
    localparam int BITPADR    = 8;
    localparam int SRAM_DELAY = 2;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic        mem_write;
    logic [3:0]  mem_wr_adr;
    logic [31:0] mem_bw, mem_din;
    logic        mem_read;
    logic [3:0]  mem_rd_adr;
    logic [31:0] dout0, dout1;
    logic        vld0, vld1, fwrd0, fwrd1, ready0, ready1;
    logic [5:0]  padr0, padr1;
`ifdef INFRA_SRAM_ERRINJ_EN
    logic        inj_en;
    logic [31:0] inj_mask;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    infra_sram_1r1w_resp #(
        .MEMWDTH(MEMWDTH), .NUMWRDS(NUMWRDS), .BITWRDS(BITWRDS), .NUMSROW(NUMSROW),
        .BITSROW(BITSROW), .BITPADR(BITPADR), .SRAM_DELAY(SRAM_DELAY), .RSTZERO(0)
    ) u_dut0 (
        .clk(clk), .rst(rst0),
        .mem_write(mem_write), .mem_wr_adr(mem_wr_adr), .mem_bw(mem_bw), .mem_din(mem_din),
        .mem_read(mem_read), .mem_rd_adr(mem_rd_adr),
`ifdef INFRA_SRAM_ERRINJ_EN
        .inj_en(inj_en), .inj_mask(inj_mask),
`endif
        .mem_rd_dout(dout0), .mem_rd_vld(vld0), .mem_rd_fwrd(fwrd0), .mem_rd_padr(padr0),
        .mem_ready(ready0)
    );

    infra_sram_1r1w_resp #(
        .MEMWDTH(MEMWDTH), .NUMWRDS(NUMWRDS), .BITWRDS(BITWRDS), .NUMSROW(NUMSROW),
        .BITSROW(BITSROW), .BITPADR(BITPADR), .SRAM_DELAY(SRAM_DELAY), .RSTZERO(1)
    ) u_dut1 (
        .clk(clk), .rst(rst1),
        .mem_write(mem_write), .mem_wr_adr(mem_wr_adr), .mem_bw(mem_bw), .mem_din(mem_din),
        .mem_read(mem_read), .mem_rd_adr(mem_rd_adr),
`ifdef INFRA_SRAM_ERRINJ_EN
        .inj_en(inj_en), .inj_mask(inj_mask),
`endif
        .mem_rd_dout(dout1), .mem_rd_vld(vld1), .mem_rd_fwrd(fwrd1), .mem_rd_padr(padr1),
        .mem_ready(ready1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_write  = 1'b0;
        mem_wr_adr = '0;
        mem_bw     = '0;
        mem_din    = '0;
        mem_read   = 1'b0;
        mem_rd_adr = '0;
`ifdef INFRA_SRAM_ERRINJ_EN
        inj_en     = 1'b0;
        inj_mask   = '0;
`endif
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] bw);
        mem_write  = 1'b1;
        mem_wr_adr = a;
        mem_din    = d;
        mem_bw     = bw;
    endtask

    task automatic test_reset();
        idle();
        rst0 = 1'b1;
        rst1 = 1'b1;
        #2;
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        n_tests++;
        if ({dout0, vld0, fwrd0, padr0, ready0} !== {32'h0, 1'b0, 1'b0, 6'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_dut0: got dout=%h vld=%b fwrd=%b padr=%h ready=%b, expected 0/0/0/0/1",
                     dout0, vld0, fwrd0, padr0, ready0);
        end
        n_tests++;
        if ({dout1, vld1, fwrd1, padr1, ready1} !== {32'h0, 1'b0, 1'b0, 6'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_dut1: got dout=%h vld=%b fwrd=%b padr=%h ready=%b, expected 0/0/0/0/0",
                     dout1, vld1, fwrd1, padr1, ready1);
        end
        step();
        step();
        rst0 = 1'b1;
    endtask

    // Releases u_dut1 reset with a read strobe held high throughout the init walk.
    task automatic test_init(input string tag);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        rst1 = 1'b1;
        mem_read   = 1'b1;
        mem_rd_adr = 4'd1;
        while (!ready1 && n < 40) begin
            step();
            n++;
            if (vld1) seen = 1'b1;
        end
        idle();
        repeat (3) begin
            step();
            if (vld1) seen = 1'b1;
        end
        n_tests++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL init_ready_cycles(%s): ready after %0d cycles, expected 16", tag, n);
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL init_read_ignored(%s): vld seen=%b, expected 0", tag, seen);
        end
    endtask

    task automatic test_write_read();
        idle();
        wr(4'd3, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        step();
        idle();
        mem_read   = 1'b1;
        mem_rd_adr = 4'd3;
        step();
        idle();
        n_tests++;
        if (vld0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_latency_early: vld=%b one cycle after issue, expected 0", vld0);
        end
        step();
        n_tests++;
        if ({vld0, dout0, fwrd0, padr0} !== {1'b1, 32'hA5A5_A5A5, 1'b0, 6'h03}) begin
            n_fail++;
            $display("FAIL rd_row3: got vld=%b dout=%h fwrd=%b padr=%h, expected 1/a5a5a5a5/0/03",
                     vld0, dout0, fwrd0, padr0);
        end
        step();
        n_tests++;
        if ({vld0, dout0, padr0} !== {1'b0, 32'hA5A5_A5A5, 6'h03}) begin
            n_fail++;
            $display("FAIL rd_hold: got vld=%b dout=%h padr=%h, expected 0/a5a5a5a5/03", vld0, dout0, padr0);
        end
    endtask

    task automatic test_forward();
        idle();
        wr(4'd5, 32'h1122_3344, 32'hFFFF_FFFF);
        step();
        wr(4'd5, 32'h0000_AA00, 32'h0000_FF00);
        mem_read   = 1'b1;
        mem_rd_adr = 4'd5;
        step();
        idle();
        step();
        n_tests++;
        if ({vld0, dout0, fwrd0, padr0} !== {1'b1, 32'h1122_AA44, 1'b1, 6'h05}) begin
            n_fail++;
            $display("FAIL fwd_merge: got vld=%b dout=%h fwrd=%b padr=%h, expected 1/1122aa44/1/05",
                     vld0, dout0, fwrd0, padr0);
        end
        mem_read   = 1'b1;
        mem_rd_adr = 4'd5;
        step();
        idle();
        step();
        n_tests++;
        if ({vld0, dout0, fwrd0} !== {1'b1, 32'h1122_AA44, 1'b0}) begin
            n_fail++;
            $display("FAIL fwd_stored: got vld=%b dout=%h fwrd=%b, expected 1/1122aa44/0", vld0, dout0, fwrd0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            idle();
            wr(4'(i), {8{4'(i)}}, 32'hFFFF_FFFF);
            step();
        end
        for (int i = 0; i <= 16; i++) begin
            idle();
            if (i < 16) begin
                mem_read   = 1'b1;
                mem_rd_adr = 4'(i);
            end
            if (i == 3) wr(4'd2, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
            step();
            if (i >= 1) begin
                n_tests++;
                if ({vld0, padr0, dout0} !== {1'b1, 6'(i - 1), {8{4'(i - 1)}}}) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d: got vld=%b padr=%h dout=%h, expected 1/%h/%h",
                             i - 1, vld0, padr0, dout0, 6'(i - 1), {8{4'(i - 1)}});
                end
            end
        end
        idle();
        step();
        n_tests++;
        if (vld0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_tail: vld=%b after burst, expected 0", vld0);
        end
        mem_read   = 1'b1;
        mem_rd_adr = 4'd2;
        step();
        idle();
        step();
        n_tests++;
        if ({vld0, dout0} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL b2b_late_write: got vld=%b dout=%h, expected 1/deadbeef", vld0, dout0);
        end
    endtask

    task automatic test_reset_flush();
        bit seen;
        seen = 1'b0;
        idle();
        mem_read   = 1'b1;
        mem_rd_adr = 4'd7;
        step();
        idle();
        step();
        mem_read   = 1'b1;
        mem_rd_adr = 4'd4;
        step();
        mem_rd_adr = 4'd5;
        #2;
        rst0 = 1'b0;
        #1;
        n_tests++;
        if ({dout0, vld0, fwrd0, padr0, ready0} !== {32'h0, 1'b0, 1'b0, 6'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_reset_vals: got dout=%h vld=%b fwrd=%b padr=%h ready=%b, expected 0/0/0/0/1",
                     dout0, vld0, fwrd0, padr0, ready0);
        end
        idle();
        step();
        step();
        rst0 = 1'b1;
        repeat (4) begin
            step();
            if (vld0) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_vld: vld seen=%b after reset, expected 0", seen);
        end
    endtask

    task automatic test_zero_init();
        for (int i = 0; i < 16; i++) begin
            idle();
            wr(4'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            step();
        end
        idle();
        mem_read   = 1'b1;
        mem_rd_adr = 4'd7;
        step();
        idle();
        step();
        n_tests++;
        if ({vld1, dout1} !== {1'b1, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL zinit_preload: got vld=%b dout=%h, expected 1/ffffffff", vld1, dout1);
        end
        rst1 = 1'b0;
        step();
        step();
        test_init("after_preload");
        mem_read   = 1'b1;
        mem_rd_adr = 4'd9;
        step();
        mem_rd_adr = 4'd0;
        step();
        idle();
        n_tests++;
        if ({vld1, dout1, padr1} !== {1'b1, 32'h0, 6'h09}) begin
            n_fail++;
            $display("FAIL zinit_row9: got vld=%b dout=%h padr=%h, expected 1/00000000/09", vld1, dout1, padr1);
        end
        step();
        n_tests++;
        if ({vld1, dout1, padr1} !== {1'b1, 32'h0, 6'h00}) begin
            n_fail++;
            $display("FAIL zinit_row0: got vld=%b dout=%h padr=%h, expected 1/00000000/00", vld1, dout1, padr1);
        end
    endtask

`ifdef INFRA_SRAM_ERRINJ_EN
    task automatic test_errinj();
        idle();
        mem_read   = 1'b1;
        mem_rd_adr = 4'd0;
        inj_en     = 1'b1;
        inj_mask   = 32'h1;
        step();
        idle();
        step();
        n_tests++;
        if ({vld1, dout1} !== {1'b1, 32'h1}) begin
            n_fail++;
            $display("FAIL errinj_on: got vld=%b dout=%h, expected 1/00000001", vld1, dout1);
        end
        mem_read   = 1'b1;
        mem_rd_adr = 4'd0;
        inj_mask   = 32'h1;
        step();
        idle();
        step();
        n_tests++;
        if ({vld1, dout1} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL errinj_off: got vld=%b dout=%h, expected 1/00000000", vld1, dout1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_init("first");
        test_write_read();
        test_forward();
        test_back_to_back();
        test_reset_flush();
        test_zero_init();
`ifdef INFRA_SRAM_ERRINJ_EN
        test_errinj();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
